// File: rtl/seq_divider_16by8_if.sv
// Operand/result handshake bundle for the sequential 2W-by-W divider.
// The master side supplies operands and consumes results; the slave side is the divider.
interface seq_divider_16by8_if #(
   parameter int W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2*W-1:0]   dividend;
   logic [W-1:0]     divisor;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   quotient;
   logic [W-1:0]     remainder;
   logic             div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider_16by8.sv
// Restoring divider: 2W-bit dividend by W-bit divisor, one quotient bit per clock,
// valid/ready on both operand and result sides; divide-by-zero short-circuits to DONE.
module seq_divider_16by8 #(
   parameter int W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   seq_divider_16by8_if.slave bus
);
   localparam int CW = $clog2(2*W);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [W:0]      prem;
   logic [2*W-1:0]  dvd;
   logic [W-1:0]    dvs;
   logic            in_ready_r;
   logic            out_valid_r;
   logic [2*W-1:0]  quo_r;
   logic [W-1:0]    rem_r;
   logic            dbz_r;
   logic [W+1:0]    step;

   // Result packs {quotient bit, next partial remainder}; tmp never exceeds 2*divisor-1,
   // so the difference always fits back into W+1 bits with the top slot free for the bit.
   function automatic logic [W+1:0] div_step(input logic [W:0] pr, input logic bitin,
                                             input logic [W-1:0] d);
      logic [W+1:0] tmp;
      logic [W+1:0] r;
      tmp = {pr, bitin};
      if (tmp >= {2'b00, d}) begin
         r        = tmp - {2'b00, d};
         r[W+1]   = 1'b1;
      end else begin
         r        = tmp;
         r[W+1]   = 1'b0;
      end
      return r;
   endfunction

   always_comb begin
      step = div_step(prem, dvd[cnt], dvs);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         prem        <= '0;
         dvd         <= '0;
         dvs         <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         quo_r       <= '0;
         rem_r       <= '0;
         dbz_r       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  dvd        <= bus.dividend;
                  dvs        <= bus.divisor;
                  in_ready_r <= 1'b0;
                  if (bus.divisor == '0) begin
                     state       <= DONE;
                     out_valid_r <= 1'b1;
                     quo_r       <= '1;
                     rem_r       <= bus.dividend[W-1:0];
                     dbz_r       <= 1'b1;
                  end else begin
                     state <= CALC;
                     cnt   <= CW'(2*W-1);
                     prem  <= '0;
                     dbz_r <= 1'b0;
                  end
               end
            end
            CALC: begin
               // quotient register doubles as the shift register; its stale bits are
               // shifted out completely after 2W steps
               prem  <= step[W:0];
               quo_r <= {quo_r[2*W-2:0], step[W+1]};
               if (cnt == '0) begin
                  state       <= DONE;
                  out_valid_r <= 1'b1;
                  rem_r       <= step[W-1:0];
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.quotient    = quo_r;
   assign bus.remainder   = rem_r;
   assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider_16by8.sv
// Scoreboard bench for seq_divider_16by8: directed corner cases, then random operands
// checked against plain integer division with random result backpressure.
module tb_seq_divider_16by8;
   localparam int W     = 8;
   localparam int NRAND = 2000;

   typedef struct {
      logic [2*W-1:0] q;
      logic [W-1:0]   r;
      logic           dz;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   acc_cyc = 0;
   bit   rdy_mode = 1'b0;
   logic rdy_val  = 1'b1;
   exp_t sb[$];

   seq_divider_16by8_if #(.W(W)) bus ();

   seq_divider_16by8 #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic exp_t model(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
      exp_t e;
      if (dv == '0) begin
         e.q  = '1;
         e.r  = dd[W-1:0];
         e.dz = 1'b1;
      end else begin
         e.q  = dd / (2*W)'(dv);
         e.r  = W'(dd % (2*W)'(dv));
         e.dz = 1'b0;
      end
      return e;
   endfunction

   // out_ready is owned by this one process; it settles after the main thread's #1 updates
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         bus.out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("quotient", 32'(bus.quotient), 32'(e.q));
            chk("remainder", 32'(bus.remainder), 32'(e.r));
            chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
      int n = 0;
      while (!bus.in_ready && n < 200) begin
         step();
         n++;
      end
      if (!bus.in_ready) begin
         chk("accept_timeout", 32'(n), 32'd0);
         return;
      end
      bus.in_valid = 1'b1;
      bus.dividend = dd;
      bus.divisor  = dv;
      @(posedge clk);
      acc_cyc = cyc;
      sb.push_back(model(dd, dv));
      #1;
      bus.in_valid = 1'b0;
      bus.dividend = (2*W)'($urandom);
      bus.divisor  = W'($urandom);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.out_valid && n < 100) begin
         step();
         n++;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || !bus.in_ready) && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) chk("idle_timeout", 32'(n), 32'd0);
   endtask

   initial begin
      int n;
      int first_acc;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) step();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_quotient", 32'(bus.quotient), 32'd0);
      chk("rst_remainder", 32'(bus.remainder), 32'd0);
      chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
      rst_n = 1'b1;
      step();

      // normal divide: latency and back-to-back spacing
      do_op(16'd1000, 8'd7);
      first_acc = acc_cyc;
      wait_valid(n);
      chk("div_latency", 32'(n), 32'(2*W));
      do_op(16'hFFFF, 8'hFF);
      chk("b2b_spacing", 32'(acc_cyc - first_acc), 32'(2*W+2));
      do_op(16'hFFFF, 8'h01);
      do_op(16'd5, 8'd10);
      do_op(16'd0, 8'd3);
      wait_idle();

      // divide by zero, then a normal op clears the flag
      do_op(16'h1234, 8'd0);
      wait_valid(n);
      chk("dbz_latency", 32'(n), 32'd0);
      chk("dbz_flag", 32'(bus.div_by_zero), 32'd1);
      do_op(16'd100, 8'd3);
      wait_idle();

      // backpressure hold
      rdy_val = 1'b0;
      do_op(16'd1000, 8'd7);
      wait_valid(n);
      for (int i = 0; i < 5; i++) begin
         chk("bp_quotient", 32'(bus.quotient), 32'd142);
         chk("bp_remainder", 32'(bus.remainder), 32'd6);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         step();
      end
      rdy_val = 1'b1;
      step();
      chk("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
      chk("bp_out_valid_after", 32'(bus.out_valid), 32'd0);
      wait_idle();

      // input isolation during CALC
      do_op(16'd50000, 8'd13);
      repeat (3) step();
      bus.in_valid = 1'b1;
      bus.dividend = 16'h0FFF;
      bus.divisor  = 8'd1;
      for (int i = 0; i < 4; i++) begin
         chk("iso_in_ready", 32'(bus.in_ready), 32'd0);
         step();
      end
      bus.in_valid = 1'b0;
      wait_idle();
      repeat (20) step();
      chk("iso_no_extra", 32'(bus.out_valid), 32'd0);

      // reset in the middle of CALC aborts the op
      do_op(16'd1000, 8'd7);
      repeat (6) step();
      rst_n = 1'b0;
      step();
      sb.delete();
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_quotient", 32'(bus.quotient), 32'd0);
      chk("mid_rst_remainder", 32'(bus.remainder), 32'd0);
      chk("mid_rst_dbz", 32'(bus.div_by_zero), 32'd0);
      rst_n = 1'b1;
      do_op(16'd200, 8'd9);
      wait_idle();

      // random operands with random result backpressure
      rdy_mode = 1'b1;
      for (int i = 0; i < NRAND; i++) begin
         logic [2*W-1:0] dd;
         logic [W-1:0]   dv;
         dd = (2*W)'($urandom);
         if (i % 16 == 0) dd = '1;
         if ($urandom_range(0, 99) < 5) dv = '0;
         else dv = W'($urandom_range(1, (1 << W) - 1));
         do_op(dd, dv);
      end
      wait_idle();
      rdy_mode = 1'b0;
      step();

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
